gray_decoder: RTL
=================

GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 SHALL have parameter N, default 4, meaning the Gray/binary word width; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  gray_in is sampled on this edge when high.
REQ-005 SHALL have port gray_in  input  N  Gray-coded count from a gray_counter or position source.
REQ-006 SHALL have port clr_err  input  1  synchronous clear of err_count.
REQ-007 SHALL have port out_valid  output  1  one-cycle pulse marking a new decoded word.
REQ-008 SHALL have port bin_out  output  N  binary value of the last accepted Gray word.
REQ-009 SHALL have port step_up  output  1  pulse: accepted word = previous + 1 mod 2^N.
REQ-010 SHALL have port step_down  output  1  pulse: accepted word = previous - 1 mod 2^N.
REQ-011 SHALL have port step_error  output  1  pulse: accepted word differs from previous by anything other than 0 or +/-1.
REQ-012 SHALL have port err_count  output  8  saturating count of step_error pulses.

Function
REQ-013 SHALL decode each bit as bin[N-1] = g[N-1] and bin[i] = bin[i+1] XOR g[i] for i = N-2 down to 0.
REQ-014 SHALL register the decoded word so that out_valid and bin_out update 1 cycle after the edge sampling in_valid=1; this is the base latency.
REQ-015 SHALL hold bin_out between accepted words; out_valid SHALL be 0 on any cycle with no new word.
REQ-016 SHALL track a primed flag: the first accepted word after reset SHALL raise out_valid with all step flags 0, then set primed.
REQ-017 SHALL compute delta = new - previous modulo 2^N on each primed accepted word.
REQ-018 SHALL assert step_up for delta = 1, step_down for delta = 2^N-1, no flag for delta = 0, and step_error for all other deltas.
REQ-019 SHALL assert step flags in the same cycle as the out_valid they qualify, for one cycle only, with at most one flag high.
REQ-020 SHALL classify wrap-around as a legal step: 2^N-1 -> 0 is step_up, and 0 -> 2^N-1 is step_down.
REQ-021 SHALL store the accepted word as the new previous value in every case, including after an error.
REQ-022 SHALL increment err_count on each step_error pulse and saturate at 255.
REQ-023 SHALL let clr_err take priority over a simultaneous increment; err_count reads 0 on the next cycle.
REQ-024 SHALL accept back-to-back in_valid on consecutive cycles at full throughput.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear out_valid, bin_out, all step flags, err_count, the previous value and primed to 0.
REQ-026 SHALL drop any word in flight when reset is asserted mid-stream, producing no out_valid for it.
REQ-027 SHALL treat the first word accepted after reset as unprimed, with no step flags.

Configuration
REQ-028 SHALL support the macro GRAY_DECODER_SYNC_EN.
REQ-029 SHALL, with GRAY_DECODER_SYNC_EN defined, pass gray_in and in_valid through a 2-stage register synchronizer before decode, making the latency 3 cycles; rst SHALL clear the synchronizer stages.
REQ-030 SHALL, without GRAY_DECODER_SYNC_EN, omit the synchronizer so latency is 1 cycle; all other behaviour is identical.

Verification
REQ-031 SHALL cover a count-up run (N=4): gray 0000, 0001, 0011 on consecutive cycles -> bin_out 0, 1, 2; flags none, step_up, step_up.
REQ-032 SHALL cover a count-down run: gray 0011 then 0001 -> bin_out 2 then 1 with step_down; repeating 0001 -> out_valid=1 with no flag.
REQ-033 SHALL cover wrap-around: gray 1000 (bin 15) then 0000 -> step_up; then 1000 -> step_down.
REQ-034 SHALL cover an error jump: gray 0000 then 0110 (bin 4) -> step_error and err_count=1; next 0111 (bin 5) -> step_up.
REQ-035 SHALL cover saturation and clear: 300 alternating 0/8 jumps -> err_count=255; clr_err together with an error -> err_count=0.
REQ-036 SHALL cover reset mid-stream: rst during a word in flight -> no out_valid; next word accepted -> out_valid with no flags; both builds checked for 1- and 3-cycle latency.

Source files
------------

// File: rtl/gray_decoder.sv
// gray_decoder: registered Gray-to-binary decoder with up/down/error step classification
// and a saturating error counter. Define GRAY_DECODER_SYNC_EN to add a 2-stage input synchronizer.
module gray_decoder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] gray_in,
    input  logic         clr_err,
    output logic         out_valid,
    output logic [N-1:0] bin_out,
    output logic         step_up,
    output logic         step_down,
    output logic         step_error,
    output logic [7:0]   err_count
);

    localparam logic [N-1:0] ZERO_C = {N{1'b0}};
    localparam logic [N-1:0] ONE_C  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ALL1_C = {N{1'b1}};

    function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b = g;
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic         dec_valid_s;
    logic [N-1:0] dec_gray_s;
    logic [N-1:0] dec_bin_s;
    logic [N-1:0] delta_s;
    logic         up_s;
    logic         down_s;
    logic         error_s;
    logic [7:0]   err_count_next_s;

    logic         out_valid_r;
    logic [N-1:0] bin_r;
    logic         primed_r;
    logic         step_up_r;
    logic         step_down_r;
    logic         step_error_r;
    logic [7:0]   err_count_r;

`ifdef GRAY_DECODER_SYNC_EN
    logic         sync1_valid_r;
    logic [N-1:0] sync1_gray_r;
    logic         sync2_valid_r;
    logic [N-1:0] sync2_gray_r;

    // Two-stage capture of the input word ahead of decode; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_valid_r <= 1'b0;
            sync1_gray_r  <= ZERO_C;
            sync2_valid_r <= 1'b0;
            sync2_gray_r  <= ZERO_C;
        end else begin
            sync1_valid_r <= in_valid;
            sync1_gray_r  <= gray_in;
            sync2_valid_r <= sync1_valid_r;
            sync2_gray_r  <= sync1_gray_r;
        end
    end

    assign dec_valid_s = sync2_valid_r;
    assign dec_gray_s  = sync2_gray_r;
`else
    assign dec_valid_s = in_valid;
    assign dec_gray_s  = gray_in;
`endif

    // Decode, classify the modular step against the previous word, and compute the next error count.
    always_comb begin
        dec_bin_s        = gray_to_bin(dec_gray_s);
        delta_s          = dec_bin_s - bin_r;
        up_s             = 1'b0;
        down_s           = 1'b0;
        error_s          = 1'b0;
        err_count_next_s = err_count_r;
        if (dec_valid_s && primed_r) begin
            case (delta_s)
                ZERO_C:  error_s = 1'b0;
                ONE_C:   up_s    = 1'b1;
                ALL1_C:  down_s  = 1'b1;
                default: error_s = 1'b1;
            endcase
        end else begin
            error_s = 1'b0;
        end
        // Clear wins over a same-cycle increment.
        if (clr_err) begin
            err_count_next_s = 8'd0;
        end else if (error_s && (err_count_r != 8'd255)) begin
            err_count_next_s = err_count_r + 8'd1;
        end else begin
            err_count_next_s = err_count_r;
        end
    end

    // Output and history registers; bin_r doubles as the previous accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            bin_r        <= ZERO_C;
            primed_r     <= 1'b0;
            step_up_r    <= 1'b0;
            step_down_r  <= 1'b0;
            step_error_r <= 1'b0;
            err_count_r  <= 8'd0;
        end else begin
            out_valid_r  <= dec_valid_s;
            step_up_r    <= up_s;
            step_down_r  <= down_s;
            step_error_r <= error_s;
            err_count_r  <= err_count_next_s;
            if (dec_valid_s) begin
                bin_r    <= dec_bin_s;
                primed_r <= 1'b1;
            end else begin
                bin_r    <= bin_r;
                primed_r <= primed_r;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign bin_out    = bin_r;
    assign step_up    = step_up_r;
    assign step_down  = step_down_r;
    assign step_error = step_error_r;
    assign err_count  = err_count_r;

endmodule
